// File: rtl/stream_mux_rr.sv
// CH-channel stream multiplexer: manual select or round-robin arbitration, one output register.
// Define STREAM_MUX_CNT_EN to add the saturating 16-bit output transfer counter xfer_count.
module stream_mux_rr #(
  parameter int unsigned N  = 4,
  parameter int unsigned CH = 4,
  parameter int unsigned SW = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH*N-1:0] in_data,
  input  logic [CH-1:0]   in_valid,
  output logic [CH-1:0]   in_ready,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  output logic [N-1:0]    out_data,
  output logic            out_valid,
  output logic [SW-1:0]   out_ch,
  input  logic            out_ready
`ifdef STREAM_MUX_CNT_EN
  ,
  output logic [15:0]     xfer_count
`endif
);

  localparam logic [SW-1:0] LastCh = SW'(CH - 1);

  logic [N-1:0]  ch_data [CH];
  logic [N-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] out_ch_q, out_ch_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] grant_idx;
  logic          grant_vld;
  logic [31:0]   cand;
  logic          accept;
  logic          xfer;

  for (genvar g = 0; g < CH; g++) begin : g_unpack
    assign ch_data[g] = in_data[g*N +: N];
  end

  // Grant only a valid candidate, so a grant always implies an input transfer when accepted.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (mode) begin
      for (int unsigned i = 0; i < CH; i++) begin
        cand = 32'(ptr_q) + i;
        // ptr_q < CH, so a single subtraction wraps the search
        if (cand >= CH) cand = cand - CH;
        if (!grant_vld && in_valid[cand[SW-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = cand[SW-1:0];
        end
      end
    end else if (32'(sel) < CH) begin
      if (in_valid[sel]) begin
        grant_vld = 1'b1;
        grant_idx = sel;
      end
    end
  end

  assign accept = !out_valid_q || out_ready;
  assign xfer   = grant_vld && accept;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = ch_data[grant_idx];
      out_ch_d    = grant_idx;
      out_valid_d = 1'b1;
      if (mode) ptr_d = (grant_idx == LastCh) ? '0 : grant_idx + 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

`ifdef STREAM_MUX_CNT_EN
  logic [15:0] xfer_count_q, xfer_count_d;

  always_comb begin
    xfer_count_d = xfer_count_q;
    if (out_valid_q && out_ready && (xfer_count_q != 16'hFFFF)) begin
      xfer_count_d = xfer_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xfer_count_q <= '0;
    else        xfer_count_q <= xfer_count_d;
  end

  assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (CH=4 and CH=3 instances) with per-instance scoreboards.
// Counter checks are included when STREAM_MUX_CNT_EN is defined.
module tb_stream_mux_rr;

  typedef struct packed {
    logic [1:0] ch;
    logic [3:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [15:0] a_data;
  logic [3:0]  a_valid, a_ready;
  logic        a_mode, a_oready, a_ovalid;
  logic [1:0]  a_sel, a_och;
  logic [3:0]  a_odata;

  logic [11:0] b_data;
  logic [2:0]  b_valid, b_ready;
  logic        b_mode, b_oready, b_ovalid;
  logic [1:0]  b_sel, b_och;
  logic [3:0]  b_odata;

`ifdef STREAM_MUX_CNT_EN
  logic [15:0] a_cnt, b_cnt;
`endif

  exp_t qa[$];
  exp_t qb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  stream_mux_rr #(.N(4), .CH(4)) u4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (a_data),
    .in_valid  (a_valid),
    .in_ready  (a_ready),
    .mode      (a_mode),
    .sel       (a_sel),
    .out_data  (a_odata),
    .out_valid (a_ovalid),
    .out_ch    (a_och),
    .out_ready (a_oready)
`ifdef STREAM_MUX_CNT_EN
    ,
    .xfer_count(a_cnt)
`endif
  );

  stream_mux_rr #(.N(4), .CH(3)) u3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (b_data),
    .in_valid  (b_valid),
    .in_ready  (b_ready),
    .mode      (b_mode),
    .sel       (b_sel),
    .out_data  (b_odata),
    .out_valid (b_ovalid),
    .out_ch    (b_och),
    .out_ready (b_oready)
`ifdef STREAM_MUX_CNT_EN
    ,
    .xfer_count(b_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] pat4(input int k);
    logic [15:0] r;
    for (int c = 0; c < 4; c++) r[c*4 +: 4] = 4'(c * 4 + k);
    return r;
  endfunction

  function automatic logic [11:0] pat3(input int k);
    logic [11:0] r;
    for (int c = 0; c < 3; c++) r[c*4 +: 4] = 4'(c * 4 + k);
    return r;
  endfunction

  // Each step's inputs are live for exactly one rising edge.
  task automatic a_step(input logic [3:0] v, input logic m, input logic [1:0] s,
                        input logic r, input int k);
    @(posedge clk);
    #1;
    a_valid  = v;
    a_mode   = m;
    a_sel    = s;
    a_oready = r;
    a_data   = pat4(k);
  endtask

  task automatic b_step(input logic [2:0] v, input logic m, input logic [1:0] s,
                        input logic r, input int k);
    @(posedge clk);
    #1;
    b_valid  = v;
    b_mode   = m;
    b_sel    = s;
    b_oready = r;
    b_data   = pat3(k);
  endtask

  // Pop on every output transfer the DUT is about to complete.
  always @(negedge clk) begin
    if (rst_n && a_ovalid && a_oready) begin
      exp_t e;
      chk("a_sb_level", 32'(qa.size() > 0), 32'd1);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_out_ch", 32'(a_och), 32'(e.ch));
        chk("a_out_data", 32'(a_odata), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_ovalid && b_oready) begin
      exp_t e;
      chk("b_sb_level", 32'(qb.size() > 0), 32'd1);
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_out_ch", 32'(b_och), 32'(e.ch));
        chk("b_out_data", 32'(b_odata), 32'(e.data));
      end
    end
  end

  initial begin
    int ch;
    rst_n = 1'b0;
    a_valid = '0; a_mode = 1'b0; a_sel = '0; a_oready = 1'b0; a_data = '0;
    b_valid = '0; b_mode = 1'b0; b_sel = '0; b_oready = 1'b0; b_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_a_valid", 32'(a_ovalid), 32'd0);
    chk("rst_a_data", 32'(a_odata), 32'd0);
    chk("rst_a_ch", 32'(a_och), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_b_valid", 32'(b_ovalid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Manual select of channel 2, one word per cycle
    for (int k = 2; k <= 5; k++) begin
      a_step(4'b1111, 1'b0, 2'd2, 1'b1, k);
      qa.push_back('{ch: 2'd2, data: 4'(8 + k)});
      @(negedge clk);
      chk("man_in_ready", 32'(a_ready), 32'b0100);
      if (k > 2) chk("man_throughput", 32'(a_ovalid), 32'd1);
    end

    // Round-robin, all channels valid
    for (int i = 0; i < 8; i++) begin
      ch = i % 4;
      a_step(4'b1111, 1'b1, 2'd0, 1'b1, 10 + i);
      qa.push_back('{ch: 2'(ch), data: 4'(ch * 4 + 10 + i)});
      @(negedge clk);
      chk("rr_all_ready", 32'(a_ready), 32'(1 << ch));
    end

    // Round-robin, only channels 1 and 3 valid
    for (int i = 0; i < 4; i++) begin
      ch = (i % 2 == 0) ? 1 : 3;
      a_step(4'b1010, 1'b1, 2'd0, 1'b1, 20 + i);
      qa.push_back('{ch: 2'(ch), data: 4'(ch * 4 + 20 + i)});
      @(negedge clk);
      chk("rr_sparse_ready", 32'(a_ready), 32'(1 << ch));
    end

    // Backpressure: hold channel-0 word for 5 cycles
    a_step(4'b1111, 1'b1, 2'd0, 1'b1, 30);
    qa.push_back('{ch: 2'd0, data: 4'hE});
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      a_step(4'b1111, 1'b1, 2'd0, 1'b0, 31 + i);
      @(negedge clk);
      chk("bp_in_ready", 32'(a_ready), 32'd0);
      chk("bp_valid", 32'(a_ovalid), 32'd1);
      chk("bp_ch", 32'(a_och), 32'd0);
      chk("bp_data", 32'(a_odata), 32'hE);
    end
    a_step(4'b1111, 1'b1, 2'd0, 1'b1, 36);
    qa.push_back('{ch: 2'd1, data: 4'(4 + 36)});
    @(negedge clk);
    chk("bp_release_ready", 32'(a_ready), 32'b0010);
    a_step(4'b0000, 1'b1, 2'd0, 1'b1, 0);
    @(negedge clk);
    chk("idle_in_ready", 32'(a_ready), 32'd0);
    a_step(4'b0000, 1'b1, 2'd0, 1'b1, 0);
    @(negedge clk);
    chk("drain_valid", 32'(a_ovalid), 32'd0);

    // Reset while a word is held
    a_step(4'b1111, 1'b1, 2'd0, 1'b0, 41);
    qa.push_back('{ch: 2'd2, data: 4'(8 + 41)});
    @(negedge clk);
    chk("pre_rst_ready", 32'(a_ready), 32'b0100);
    a_step(4'b0000, 1'b1, 2'd0, 1'b0, 0);
    @(negedge clk);
    chk("pre_rst_held", 32'(a_ovalid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(a_ovalid), 32'd0);
    chk("mid_rst_data", 32'(a_odata), 32'd0);
    chk("mid_rst_ch", 32'(a_och), 32'd0);
    qa.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Ten transfers after reset; pointer restarts at channel 0
    for (int i = 0; i < 10; i++) begin
      ch = i % 4;
      a_step(4'b1111, 1'b1, 2'd0, 1'b1, 50 + i);
      qa.push_back('{ch: 2'(ch), data: 4'(ch * 4 + 50 + i)});
      @(negedge clk);
      chk("post_rst_rr_ready", 32'(a_ready), 32'(1 << ch));
    end
    a_step(4'b0000, 1'b1, 2'd0, 1'b1, 0);
    a_step(4'b0000, 1'b1, 2'd0, 1'b1, 0);
    @(negedge clk);
    chk("post_rst_drained", 32'(a_ovalid), 32'd0);
`ifdef STREAM_MUX_CNT_EN
    chk("cnt_ten", 32'(a_cnt), 32'd10);
    force u4.xfer_count_q = 16'hFFFE;
    #1 release u4.xfer_count_q;
    for (int i = 0; i < 3; i++) begin
      ch = (i + 2) % 4;
      a_step(4'b1111, 1'b1, 2'd0, 1'b1, 60 + i);
      qa.push_back('{ch: 2'(ch), data: 4'(ch * 4 + 60 + i)});
    end
    a_step(4'b0000, 1'b1, 2'd0, 1'b1, 0);
    a_step(4'b0000, 1'b1, 2'd0, 1'b1, 0);
    @(negedge clk);
    chk("cnt_saturate", 32'(a_cnt), 32'hFFFF);
`endif

    // CH=3: pointer wraps after channel 2
    for (int i = 0; i < 4; i++) begin
      ch = i % 3;
      b_step(3'b111, 1'b1, 2'd0, 1'b1, 60 + i);
      qb.push_back('{ch: 2'(ch), data: 4'(ch * 4 + 60 + i)});
      @(negedge clk);
      chk("np2_rr_ready", 32'(b_ready), 32'(1 << ch));
    end
    b_step(3'b111, 1'b0, 2'd3, 1'b1, 70);
    @(negedge clk);
    chk("np2_sel_oob_ready", 32'(b_ready), 32'd0);
    b_step(3'b111, 1'b0, 2'd3, 1'b1, 71);
    @(negedge clk);
    chk("np2_sel_oob_drain", 32'(b_ovalid), 32'd0);
    b_step(3'b111, 1'b0, 2'd1, 1'b1, 72);
    qb.push_back('{ch: 2'd1, data: 4'(4 + 72)});
    @(negedge clk);
    chk("np2_man_ready", 32'(b_ready), 32'b010);
    b_step(3'b000, 1'b0, 2'd1, 1'b1, 0);
    b_step(3'b000, 1'b0, 2'd1, 1'b1, 0);
    @(negedge clk);
    chk("np2_drained", 32'(b_ovalid), 32'd0);

    chk("a_sb_empty_end", 32'(qa.size()), 32'd0);
    chk("b_sb_empty_end", 32'(qb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
